// File: rtl/logic_op_pkg.sv
// Shared types and constants for the shared bitwise logic unit and its two-port arbiter.
package logic_op_pkg;

  localparam int OPS_CNT_W = 8;

  typedef enum logic [1:0] {
    OR   = 2'b00,
    AND  = 2'b01,
    XOR  = 2'b10,
    NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit: OR / AND / XOR / NAND of two WIDTH-bit operands.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  // Opcode decode into the selected bitwise function
  always_comb begin
    y = '0;
    case (op)
      OR:      y = a | b;
      AND:     y = a & b;
      XOR:     y = a ^ b;
      NAND:    y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter serialising two requesters onto one logic_op_unit,
// with valid/ready capture on the request side and a held result on the response side.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [1:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [1:0]           req1_op,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_id,
  output logic                 busy,
  output logic [OPS_CNT_W-1:0] ops_done
);

  state_e                 state_q;
  logic                   last_grant_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  op_e                    op_q;
  logic                   id_q;
  logic                   res_valid_q;
  logic [WIDTH-1:0]       res_data_q;
  logic                   res_id_q;
  logic                   busy_q;
  logic [OPS_CNT_W-1:0]   ops_done_q;
  logic [OPS_CNT_W-1:0]   ops_done_d;

  logic                   grant_s;
  logic                   accept_s;
  logic [WIDTH-1:0]       a_sel_s;
  logic [WIDTH-1:0]       b_sel_s;
  logic [1:0]             op_sel_s;
  logic [WIDTH-1:0]       y_s;

  // Grant: a lone requester wins; on a tie the one not granted last time wins
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Readies only in IDLE and never during reset; operand mux follows the grant
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      req0_ready = req0_valid && !grant_s;
      req1_ready = req1_valid && grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    accept_s   = req0_ready || req1_ready;
    a_sel_s    = grant_s ? req1_a  : req0_a;
    b_sel_s    = grant_s ? req1_b  : req0_b;
    op_sel_s   = grant_s ? req1_op : req0_op;
    ops_done_d = ops_done_q + OPS_CNT_W'(1);
  end

  logic_op_unit #(
    .WIDTH(WIDTH)
  ) u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (y_s)
  );

  // FSM with capture registers, registered result and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OR;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q          <= a_sel_s;
            b_q          <= b_sel_s;
            op_q         <= op_e'(op_sel_s);
            id_q         <= grant_s;
            last_grant_q <= grant_s;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= y_s;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ops_done_q  <= ops_done_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed scoreboard bench for logic_op_arbiter (8-bit instance plus a 16-bit NAND corner instance).
module tb_logic_op_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, res_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [7:0]  res_data, ops_done;

  logic        v16_valid;
  logic [15:0] v16_a, v16_b;
  logic [1:0]  v16_op;
  logic        r16_rdy0, r16_rdy1, r16_res_valid, r16_res_id, r16_busy;
  logic [15:0] r16_res_data;
  logic [7:0]  r16_ops;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_ops = 0;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .ops_done(ops_done)
  );

  logic_op_arbiter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .req0_valid(v16_valid), .req0_ready(r16_rdy0), .req0_a(v16_a), .req0_b(v16_b), .req0_op(v16_op),
    .req1_valid(1'b0), .req1_ready(r16_rdy1), .req1_a(16'h0000), .req1_b(16'h0000), .req1_op(2'b00),
    .res_valid(r16_res_valid), .res_ready(1'b1), .res_data(r16_res_data), .res_id(r16_res_id),
    .busy(r16_busy), .ops_done(r16_ops)
  );

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
  endtask

  task automatic wait_ready(input logic id, input string tag);
    int n = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check(tag, 32'(id ? req1_ready : req0_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while ((res_valid !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  // Compare the presented result against the scoreboard head; res_ready must be high.
  task automatic pop_check(input string tag);
    logic [8:0] e;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL %s_sb: observed=result expected=empty_scoreboard", tag);
    end
    e = (sb.size() > 0) ? sb.pop_front() : 9'h000;
    check({tag, "_data"}, 32'(res_data), 32'(e[7:0]));
    check({tag, "_id"}, 32'(res_id), 32'(e[8]));
    tick();
    exp_ops++;
    check({tag, "_ops"}, 32'(ops_done), 32'(exp_ops % 256));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp, input string tag);
    drive(id, a, b, op);
    wait_ready(id, {tag, "_rdy"});
    sb.push_back({id, exp});
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_valid({tag, "_vld"});
    pop_check(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    res_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    v16_valid = 1'b0;
    tick();
    tick();
    sb.delete();
    exp_ops = 0;
    check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
    check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_data"}, 32'(res_data), 32'd0);
    check({tag, "_id"}, 32'(res_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ops"}, 32'(ops_done), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'b00;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 2'b00;
    res_ready = 1'b0;
    v16_valid = 1'b0; v16_a = 16'h0000; v16_b = 16'h0000; v16_op = 2'b00;

    // Single request: accept on first edge, result one cycle in EXEC later
    do_reset("rst0");
    res_ready = 1'b1;
    drive(1'b0, 8'hF0, 8'h0F, 2'b00);
    check("t1_rdy0", 32'(req0_ready), 32'd1);
    check("t1_rdy1", 32'(req1_ready), 32'd0);
    sb.push_back({1'b0, 8'hFF});
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_exec_busy", 32'(busy), 32'd1);
    check("t1_exec_valid", 32'(res_valid), 32'd0);
    check("t1_exec_rdy0", 32'(req0_ready), 32'd0);
    tick();
    check("t1_resp_valid", 32'(res_valid), 32'd1);
    pop_check("t1");

    // Contention: req0 wins first tie, then strict alternation
    do_reset("rst1");
    res_ready = 1'b1;
    drive(1'b0, 8'hCC, 8'hAA, 2'b01);
    drive(1'b1, 8'hCC, 8'hAA, 2'b10);
    check("t2_tie_rdy0", 32'(req0_ready), 32'd1);
    check("t2_tie_rdy1", 32'(req1_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sb.push_back({i[0], (i[0] ? 8'h66 : 8'h88)});
    end
    for (int i = 0; i < 4; i++) begin
      wait_valid("t2_vld");
      pop_check("t2");
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Backpressure: result held, readies low, busy high while res_ready is low
    res_ready = 1'b0;
    drive(1'b0, 8'h3C, 8'hA5, 2'b10);
    check("t3_rdy0", 32'(req0_ready), 32'd1);
    sb.push_back({1'b0, 8'h99});
    tick();
    req0_valid = 1'b0;
    drive(1'b1, 8'hF0, 8'h33, 2'b01);
    sb.push_back({1'b1, 8'h30});
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(res_valid), 32'd1);
      check("t3_hold_data", 32'(res_data), 32'h99);
      check("t3_hold_id", 32'(res_id), 32'd0);
      check("t3_hold_rdy0", 32'(req0_ready), 32'd0);
      check("t3_hold_rdy1", 32'(req1_ready), 32'd0);
      check("t3_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    #1;
    pop_check("t3a");
    check("t3_next_rdy1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    wait_valid("t3b_vld");
    pop_check("t3b");

    // NAND corners on both widths
    issue(1'b0, 8'hFF, 8'hFF, 2'b11, 8'h00, "t4_nand_ff");
    issue(1'b0, 8'h00, 8'h00, 2'b11, 8'hFF, "t4_nand_00");
    issue(1'b1, 8'hA5, 8'h0F, 2'b11, 8'hFA, "t4_nand_r1");
    v16_valid = 1'b1; v16_a = 16'hFFFF; v16_b = 16'h0F0F; v16_op = 2'b11;
    #1;
    check("t4_w16_rdy", 32'(r16_rdy0), 32'd1);
    tick();
    v16_valid = 1'b0;
    tick();
    check("t4_w16_valid", 32'(r16_res_valid), 32'd1);
    check("t4_w16_data", 32'(r16_res_data), 32'hF0F0);
    check("t4_w16_id", 32'(r16_res_id), 32'd0);
    tick();
    check("t4_w16_ops", 32'(r16_ops), 32'd1);
    check("t4_w16_busy", 32'(r16_busy), 32'd0);

    // Reset during EXEC discards the op; req0 wins the next tie, req1 then served
    do_reset("rst2");
    res_ready = 1'b1;
    drive(1'b0, 8'hF0, 8'h0F, 2'b00);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t5_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ops", 32'(ops_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_result", 32'(res_valid), 32'd0);
    end
    drive(1'b0, 8'h12, 8'h34, 2'b01);
    drive(1'b1, 8'h12, 8'h34, 2'b10);
    check("t5_tie_rdy0", 32'(req0_ready), 32'd1);
    sb.push_back({1'b0, 8'h10});
    sb.push_back({1'b1, 8'h26});
    wait_valid("t5a_vld");
    pop_check("t5a");
    req0_valid = 1'b0;
    wait_valid("t5b_vld");
    pop_check("t5b");
    req1_valid = 1'b0;
    #1;

    // Counter wrap: 256 completions back to 0, 257th reads 1
    do_reset("rst3");
    res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, b;
      logic [1:0] op;
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      op = 2'($urandom_range(0, 3));
      issue(i[0], a, b, op, model(a, b, op), "t6");
    end
    check("t6_wrap0", 32'(ops_done), 32'd0);
    issue(1'b0, 8'h55, 8'hAA, 2'b10, 8'hFF, "t6_257");
    check("t6_wrap1", 32'(ops_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
